// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit owning the MIPS HI/LO pair.
// One bit per cycle: shift-add multiply, restoring divide, sign fix-up on commit.
module mips_cpu_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] p_hi;     // partial product high half / remainder
    logic [WIDTH-1:0] p_lo;     // multiplier being consumed / quotient being built
    logic [WIDTH-1:0] opnd;     // multiplicand or divisor magnitude
    logic             is_div;
    logic             neg_res;
    logic             neg_rem;
    logic             dz;

    logic             accept_md;
    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign accept_md = start && (op[2] == 1'b0);
    assign is_signed = (op[0] == 1'b0);
    assign a_neg     = is_signed && a[WIDTH-1];
    assign b_neg     = is_signed && b[WIDTH-1];
    assign a_mag     = a_neg ? (~a + 1'b1) : a;
    assign b_mag     = b_neg ? (~b + 1'b1) : b;

    assign add_sum  = {1'b0, p_hi} + {1'b0, (p_lo[0] ? opnd : {WIDTH{1'b0}})};
    // Remainder is always below the divisor, so the W+1-bit trial's MSB is a clean borrow.
    assign trial    = {p_hi, p_lo[WIDTH-1]} - {1'b0, opnd};
    assign prod_fix = neg_res ? (~{p_hi, p_lo} + 1'b1) : {p_hi, p_lo};
    assign quo_fix  = neg_res ? (~p_lo + 1'b1) : p_lo;
    assign rem_fix  = neg_rem ? (~p_hi + 1'b1) : p_hi;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_md) state_next = RUN;
            RUN:     if (cnt == CW'(1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
            p_hi     <= '0;
            p_lo     <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz       <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_md) begin
                        busy    <= 1'b1;
                        cnt     <= CW'(WIDTH);
                        is_div  <= op[1];
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        dz      <= op[1] && (b == '0);
                        p_hi    <= '0;
                        opnd    <= op[1] ? b_mag : a_mag;
                        p_lo    <= op[1] ? a_mag : b_mag;
                    end else if (start && op == 3'b100) begin
                        hi <= a;
                    end else if (start && op == 3'b101) begin
                        lo <= a;
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (is_div) begin
                        if (trial[WIDTH]) begin
                            p_hi <= {p_hi[WIDTH-2:0], p_lo[WIDTH-1]};
                            p_lo <= {p_lo[WIDTH-2:0], 1'b0};
                        end else begin
                            p_hi <= trial[WIDTH-1:0];
                            p_lo <= {p_lo[WIDTH-2:0], 1'b1};
                        end
                    end else begin
                        p_hi <= add_sum[WIDTH:1];
                        p_lo <= {add_sum[0], p_lo[WIDTH-1:1]};
                    end
                end
                FINISH: begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    div_zero <= dz;
                    if (!is_div) begin
                        {hi, lo} <= prod_fix;
                    end else if (!dz) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: busy <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv: directed cases plus random ops
// checked against a 64-bit arithmetic reference of HI/LO.
module tb_mips_cpu_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mips_cpu_muldiv #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference: updates exp_hi/exp_lo from plain arithmetic, returns divide-by-zero.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic dz);
        longint      sx, sy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        dz = 1'b0;
        case (o)
            3'd0: begin p = 64'(sx * sy); {exp_hi, exp_lo} = p; end
            3'd1: begin p = {32'b0, x} * {32'b0, y}; {exp_hi, exp_lo} = p; end
            3'd2: if (y == 0) dz = 1'b1;
                  else begin
                      exp_lo = 32'(sx / sy);
                      exp_hi = 32'(sx % sy);
                  end
            3'd3: if (y == 0) dz = 1'b1;
                  else begin
                      exp_lo = x / y;
                      exp_hi = x % y;
                  end
            3'd4: exp_hi = x;
            3'd5: exp_lo = x;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input string tag);
        int   cnt;
        logic dz;
        model(o, x, y, dz);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        if (o <= 3'd3) begin
            cnt = 0;
            while (busy && cnt < 100) begin
                cnt++;
                @(negedge clk);
            end
            check({tag, " busy_cycles"}, 64'(cnt), 64'd33);
            check({tag, " done"}, 64'(done), 64'd1);
            check({tag, " div_zero"}, 64'(div_zero), 64'(dz));
        end else begin
            check({tag, " busy"}, 64'(busy), 64'd0);
            check({tag, " done"}, 64'(done), 64'd0);
        end
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    endtask

    task automatic wait_done(input string tag);
        int cnt;
        cnt = 0;
        while (!done && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check({tag, " done"}, 64'(done), 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic dz;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset div_zero", 64'(div_zero), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);

        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");
        check("mult_neg3x7 hi const", 64'(hi), 64'hFFFF_FFFF);
        check("mult_neg3x7 lo const", 64'(lo), 64'hFFFF_FFEB);
        @(negedge clk);
        check("done one-cycle pulse", 64'(done), 64'd0);

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        check("multu_max hi const", 64'(hi), 64'hFFFF_FFFE);
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1xm1");
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
        check("div_neg7by2 lo const", 64'(lo), 64'hFFFF_FFFD);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        check("div_overflow lo const", 64'(lo), 64'h8000_0000);
        run_op(3'd4, 32'h1234_5678, 32'd0, "mthi");
        run_op(3'd3, 32'd7, 32'd0, "divu_by0");
        check("divu_by0 hi const", 64'(hi), 64'h1234_5678);

        // MTLO issued while busy must be dropped.
        model(3'd1, 32'd5, 32'd6, dz);
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'h0000_DEAD;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_mtlo");
        check("busy_mtlo hi", 64'(hi), 64'd0);
        check("busy_mtlo lo", 64'(lo), 64'd30);

        // Reset mid-operation abandons the MULTU.
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'h1234; b = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset done", 64'(done), 64'd0);
        check("midreset hi", 64'(hi), 64'd0);
        check("midreset lo", 64'(lo), 64'd0);
        run_op(3'd1, 32'd3, 32'd4, "multu_3x4");

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mips_cpu_muldiv.md
# mips_cpu_muldiv

Multi-cycle multiply/divide unit that owns the HI/LO register pair of the MIPS datapath. It executes MULT, MULTU, DIV, DIVU iteratively (one bit per cycle) and MTHI/MTLO in a single cycle, beside the combinational ALU. The control unit starts an operation with a start/busy/done handshake and stalls while the unit is busy. Operand width is parametrised; the CPU instantiates it with WIDTH=32.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be ≥ 4 and even.
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled on each rising edge while busy=0.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved (ignored).
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source).
- b  in  WIDTH  rt operand (divisor / multiplier).
- busy  out  1  high while a MULT/DIV is in flight.
- done  out  1  one-cycle pulse when a MULT/DIV result is committed.
- div_zero  out  1  pulses with done when a DIV/DIVU had b=0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- Reset: hi=0, lo=0, busy=0, done=0, div_zero=0, state IDLE. Reset mid-operation abandons the operation; no partial result reaches hi/lo.
- States: IDLE, RUN, FINISH.
  - IDLE: start=1 with op MULT/MULTU/DIV/DIVU → latch a, b, op; load iteration counter; → RUN. start=1 with MTHI → hi<=a; with MTLO → lo<=a; stay IDLE. Reserved op or start=0 → no change.
  - RUN: one iteration per cycle, WIDTH iterations; after the last → FINISH.
  - FINISH: write hi/lo (unless divide-by-zero), pulse done (and div_zero if applicable) → IDLE.
- Signed ops (MULT, DIV): take operand magnitudes, run the unsigned core, then correct signs. Product negated if signs differ. Quotient negated if signs differ (truncation toward zero). Remainder takes the sign of the dividend.
- MULT/MULTU: {hi,lo} <= full 2·WIDTH-bit product. Shift-add core.
- DIV/DIVU: lo <= quotient, hi <= remainder. Restoring core.
- Divide by zero (b=0): same latency; hi/lo keep their previous values; div_zero=1 in the done cycle.
- Signed overflow (DIV of -2^(WIDTH-1) by -1): lo = -2^(WIDTH-1) (bit pattern 100…0), hi = 0. No flag.
- start while busy=1: ignored entirely, including MTHI/MTLO. The requester must hold or re-issue.
- a, b, op may change freely after acceptance; latched copies are used.

## Timing
- Start accepted at edge E0.
- busy is 1 during the WIDTH+1 cycles following E0 (RUN ×WIDTH, FINISH ×1).
- hi/lo update at edge E(WIDTH+1). done (and div_zero) is high exactly for the cycle after E(WIDTH+1), and busy is 0 in that same cycle.
- Total latency: WIDTH+1 cycles from the accept edge to visible result, i.e. 33 for WIDTH=32.
- A new start may be accepted at the edge ending the done cycle; back-to-back throughput is one operation per WIDTH+2 cycles.
- MTHI/MTLO: hi/lo visible the cycle after the accept edge; busy and done stay 0.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- WIDTH=32, MULT a=0xFFFFFFFD (-3), b=7 → after 33 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB. busy high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then MULT of the same operands → hi=0, lo=1.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI a=0x12345678, then DIVU a=7, b=0 → after 33 cycles done=1, div_zero=1, hi=0x12345678 and lo unchanged.
- MULTU 5×6 started, MTLO a=0xDEAD issued at cycle 3 (busy) → the MTLO is ignored; final hi=0, lo=30.
- MULTU started, reset asserted at cycle 10 → next cycle busy=0, done=0, hi=lo=0. A fresh MULTU 3×4 then gives lo=12 after 33 cycles.
